// File: rtl/stage_block_gen.sv
// stage_block_gen: pseudo-random stage block generator.
// A 16-bit Galois LFSR drives block gaps, widths and heights. Records are
// queued in a small FIFO so the generated sequence depends only on the seed,
// never on consumer back-pressure.
`timescale 1ns/1ps
module stage_block_gen #(
  parameter int unsigned POS_DIGIT  = 16,
  parameter int unsigned BLK_BITS   = 52,
  parameter int unsigned MAP_LENGTH = 10000,
  parameter int unsigned FIRST_W    = 200,
  parameter int unsigned GAP_MIN    = 40,
  parameter int unsigned GAP_BITS   = 6,
  parameter int unsigned W_MIN      = 120,
  parameter int unsigned W_BITS     = 7,
  parameter int unsigned H_MIN      = 60,
  parameter int unsigned H_BITS     = 7,
  parameter int unsigned TOP_H_MIN  = 100,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                i_clk_pix,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic [15:0]         i_seed,
  input  logic                i_ready,
  output logic                o_valid,
  output logic [BLK_BITS-1:0] o_blk,
  output logic                o_done,
  output logic [15:0]         o_count
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GEN  = 2'd1;
  localparam logic [1:0] ST_END  = 2'd2;

  localparam logic [15:0] LFSR_INIT = 16'hACE1;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  localparam logic [POS_DIGIT-1:0] MAP_LAST    = POS_DIGIT'(MAP_LENGTH - 1);
  localparam logic [POS_DIGIT-1:0] GAP_STEP    = POS_DIGIT'(GAP_MIN + 1);
  localparam logic [POS_DIGIT-1:0] W_BASE      = POS_DIGIT'(W_MIN);
  localparam logic [POS_DIGIT-1:0] H_BASE      = POS_DIGIT'(H_MIN);
  localparam logic [POS_DIGIT-1:0] TOP_H_BASE  = POS_DIGIT'(TOP_H_MIN);
  localparam logic [POS_DIGIT-1:0] FIRST_RIGHT = POS_DIGIT'(FIRST_W - 1);
  localparam logic [CNT_W-1:0]     CNT_FULL    = CNT_W'(FIFO_DEPTH);

  logic [1:0]           state_q;
  logic [15:0]          lfsr_q;
  logic [15:0]          lfsr_next;
  logic [POS_DIGIT-1:0] prev_right_q;
  logic                 prev_top_q;
  logic                 first_q;
  logic [15:0]          count_q;

  logic [BLK_BITS-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q;
  logic [PTR_W-1:0]     rd_ptr_q;
  logic [CNT_W-1:0]     fifo_cnt_q;

  logic [POS_DIGIT-1:0] cand_left;
  logic [POS_DIGIT-1:0] cand_right_raw;
  logic [POS_DIGIT-1:0] cand_right;
  logic [POS_DIGIT-1:0] cand_height;
  logic                 cand_top;
  logic                 cand_past_end;

  logic [POS_DIGIT-1:0] new_right;
  logic                 new_top;
  logic [BLK_BITS-1:0]  new_rec;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 pop;
  logic                 gen_active;
  logic                 hit_end;
  logic                 push;

  // Candidate record from the current LFSR value and the previous block.
  always_comb begin
    cand_left      = prev_right_q + GAP_STEP + POS_DIGIT'(lfsr_q[GAP_BITS-1:0]);
    cand_right_raw = cand_left + W_BASE + POS_DIGIT'(lfsr_q[W_BITS+5:6]);
    cand_right     = (cand_right_raw > MAP_LAST) ? MAP_LAST : cand_right_raw;
    // A ceiling block never directly follows another ceiling block.
    cand_top       = (lfsr_q[15:13] == 3'b111) && !prev_top_q;
    cand_height    = (cand_top ? TOP_H_BASE : H_BASE) + POS_DIGIT'(lfsr_q[H_BITS+5:6]);
    cand_past_end  = cand_left > MAP_LAST;
    lfsr_next      = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
  end

  // Select the fixed opening block or the random candidate.
  always_comb begin
    if (first_q) begin
      new_right = FIRST_RIGHT;
      new_top   = 1'b0;
      new_rec   = {{POS_DIGIT{1'b0}}, FIRST_RIGHT, H_BASE, 4'h0};
    end else begin
      new_right = cand_right;
      new_top   = cand_top;
      new_rec   = {cand_left, cand_right, cand_height, 3'b000, cand_top};
    end
  end

  // Handshake and push/pop decisions; a full FIFO accepts a push alongside a pop.
  always_comb begin
    fifo_full  = (fifo_cnt_q == CNT_FULL);
    fifo_empty = (fifo_cnt_q == '0);
    pop        = !fifo_empty && i_ready;
    gen_active = (state_q == ST_GEN) && !i_start;
    hit_end    = gen_active && !first_q && cand_past_end;
    push       = gen_active && !hit_end && (!fifo_full || pop);
  end

  // FSM, LFSR and previous-block tracking; the LFSR moves only on a random push.
  always_ff @(posedge i_clk_pix) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      lfsr_q       <= LFSR_INIT;
      prev_right_q <= '0;
      prev_top_q   <= 1'b0;
      first_q      <= 1'b0;
    end else if (i_start) begin
      state_q      <= ST_GEN;
      lfsr_q       <= (i_seed == 16'h0000) ? LFSR_INIT : i_seed;
      prev_right_q <= '0;
      prev_top_q   <= 1'b0;
      first_q      <= 1'b1;
    end else begin
      if (hit_end) begin
        state_q <= ST_END;
      end
      if (push) begin
        prev_right_q <= new_right;
        prev_top_q   <= new_top;
        first_q      <= 1'b0;
        if (!first_q) begin
          lfsr_q <= lfsr_next;
        end
      end
    end
  end

  // FIFO pointers and occupancy; start flushes the queue.
  always_ff @(posedge i_clk_pix) begin
    if (!i_rst_n || i_start) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      fifo_cnt_q <= fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // FIFO storage; contents are don't-care while the occupancy is zero.
  always_ff @(posedge i_clk_pix) begin
    if (push) begin
      mem_q[wr_ptr_q] <= new_rec;
    end
  end

  // Saturating count of records popped since start.
  always_ff @(posedge i_clk_pix) begin
    if (!i_rst_n || i_start) begin
      count_q <= '0;
    end else if (pop && (count_q != 16'hFFFF)) begin
      count_q <= count_q + 16'd1;
    end
  end

  // Outputs come straight from registers, so there is no path from i_ready.
  always_comb begin
    o_valid = !fifo_empty;
    o_blk   = mem_q[rd_ptr_q];
    o_done  = (state_q == ST_END) && fifo_empty;
    o_count = count_q;
  end

endmodule

// File: tb/tb_stage_block_gen.sv
// Directed bench for stage_block_gen: hand-computed records for seed 16'h1234,
// back-pressure, zero seed, map end, reset mid-stream and the ceiling rule.
`timescale 1ns/1ps
module tb_stage_block_gen;

  logic        clk;
  logic        rst_n;
  logic        start_a, start_b;
  logic [15:0] seed_a, seed_b;
  logic        rdy_a, rdy_b;
  logic        valid_a, valid_b;
  logic [51:0] blk_a, blk_b;
  logic        done_a, done_b;
  logic [15:0] count_a, count_b;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [15:0] m_lfsr;
  logic [15:0] m_prev_right;
  logic        m_prev_top;
  logic        m_first;
  logic        m_ended;

  stage_block_gen dut_a (
    .i_clk_pix (clk),
    .i_rst_n   (rst_n),
    .i_start   (start_a),
    .i_seed    (seed_a),
    .i_ready   (rdy_a),
    .o_valid   (valid_a),
    .o_blk     (blk_a),
    .o_done    (done_a),
    .o_count   (count_a)
  );

  stage_block_gen #(.MAP_LENGTH(1000)) dut_b (
    .i_clk_pix (clk),
    .i_rst_n   (rst_n),
    .i_start   (start_b),
    .i_seed    (seed_b),
    .i_ready   (rdy_b),
    .o_valid   (valid_b),
    .o_blk     (blk_b),
    .o_done    (done_b),
    .o_count   (count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input logic [15:0] s);
    m_lfsr       = (s == 16'h0000) ? 16'hACE1 : s;
    m_prev_right = 16'd0;
    m_prev_top   = 1'b0;
    m_first      = 1'b1;
    m_ended      = 1'b0;
  endtask

  task automatic model_next(input int map_len, output logic [51:0] rec, output bit ended);
    logic [15:0] left, right, height;
    logic        top;
    rec   = '0;
    ended = 1'b0;
    if (m_ended) begin
      ended = 1'b1;
    end else if (m_first) begin
      rec          = {16'd0, 16'd199, 16'd60, 4'h0};
      m_prev_right = 16'd199;
      m_prev_top   = 1'b0;
      m_first      = 1'b0;
    end else begin
      left = m_prev_right + 16'd41 + {10'd0, m_lfsr[5:0]};
      if (int'(left) > map_len - 1) begin
        m_ended = 1'b1;
        ended   = 1'b1;
      end else begin
        right = left + 16'd120 + {9'd0, m_lfsr[12:6]};
        if (int'(right) > map_len - 1) right = 16'(map_len - 1);
        top    = (m_lfsr[15:13] == 3'b111) && !m_prev_top;
        height = (top ? 16'd100 : 16'd60) + {9'd0, m_lfsr[12:6]};
        rec    = {left, right, height, 3'b000, top};
        m_prev_right = right;
        m_prev_top   = top;
        m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
      end
    end
  endtask

  task automatic start_pulse(input int sel, input logic [15:0] s);
    @(negedge clk);
    if (sel == 0) begin start_a = 1'b1; seed_a = s; end
    else begin start_b = 1'b1; seed_b = s; end
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Pop one record; ready is random when rnd is set. Bounded wait.
  task automatic pop_rec(input int sel, input bit rnd, output logic [51:0] rec, output bit ok);
    logic r;
    ok  = 1'b0;
    rec = '0;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clk);
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (sel == 0) rdy_a = r; else rdy_b = r;
      if (r && (sel == 0 ? valid_a : valid_b)) begin
        rec = (sel == 0) ? blk_a : blk_b;
        ok  = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    rdy_a = 1'b0;
    rdy_b = 1'b0;
  endtask

  task automatic pop_expect(input int sel, input string tag, input logic [51:0] exp);
    logic [51:0] rec;
    bit          ok;
    pop_rec(sel, 1'b0, rec, ok);
    check({tag, "_pop_ok"}, 64'(ok), 64'd1);
    check(tag, 64'(rec), 64'(exp));
  endtask

  // Pop up to n records against the model, stopping where the model reaches map end.
  task automatic model_run(input string tag, input bit rnd, input int n);
    logic [51:0] rec, exp;
    bit          ok, ended;
    int          bad;
    bad = 0;
    ended = 1'b0;
    for (int i = 0; i < n && !ended; i++) begin
      model_next(10000, exp, ended);
      if (!ended) begin
        pop_rec(0, rnd, rec, ok);
        if (!ok || rec !== exp) bad++;
      end
    end
    check({tag, "_seq_bad"}, 64'(bad), 64'd0);
  endtask

  initial begin
    logic [51:0] rec, exp;
    bit          ok, ended, found, seen;
    int          seq_bad, ceil_bad, order_bad, total_recs, ceil_recs, dn;
    logic        prev_stat;
    logic [15:0] prev_left, s;

    rst_n = 1'b0;
    start_a = 1'b0; start_b = 1'b0;
    seed_a = 16'h0; seed_b = 16'h0;
    rdy_a = 1'b0; rdy_b = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(valid_a), 64'd0);
    check("rst_done", 64'(done_a), 64'd0);
    check("rst_count", 64'(count_a), 64'd0);
    check("rst_lfsr", 64'(dut_a.lfsr_q), 64'hACE1);
    check("rst_state", 64'(dut_a.state_q), 64'd0);
    rst_n = 1'b1;

    // Startup with seed 16'h1234: hand-computed records
    start_pulse(0, 16'h1234);
    pop_expect(0, "start_rec0", {16'd0, 16'd199, 16'd60, 4'h0});
    pop_rec(0, 1'b0, rec, ok);
    check("start_rec1", 64'(rec), 64'({16'd292, 16'd484, 16'd132, 4'h0}));
    check("start_rec1_left_range", 64'((rec[51:36] >= 16'd240) && (rec[51:36] <= 16'd303)), 64'd1);
    check("start_count2", 64'(count_a), 64'd2);
    pop_expect(0, "start_rec2", {16'd551, 16'd707, 16'd96, 4'h0});
    pop_expect(0, "start_rec3", {16'd761, 16'd899, 16'd78, 4'h0});
    pop_expect(0, "start_rec4", {16'd946, 16'd1155, 16'd149, 4'h0});
    check("start_count5", 64'(count_a), 64'd5);

    // Back-pressure independence: steady ready, then random ready
    start_pulse(0, 16'h1234);
    model_reset(16'h1234);
    model_run("bp_steady", 1'b0, 50);
    start_pulse(0, 16'h1234);
    model_reset(16'h1234);
    model_run("bp_random", 1'b1, 50);

    // Ready held low: FIFO fills to 4 and the LFSR freezes after three advances
    rdy_a = 1'b0;
    start_pulse(0, 16'h1234);
    repeat (20) @(negedge clk);
    check("hold_fifo_cnt", 64'(dut_a.fifo_cnt_q), 64'd4);
    check("hold_lfsr", 64'(dut_a.lfsr_q), 64'hB646);
    check("hold_valid", 64'(valid_a), 64'd1);
    check("hold_count", 64'(count_a), 64'd0);
    repeat (5) @(negedge clk);
    check("hold_lfsr_frozen", 64'(dut_a.lfsr_q), 64'hB646);

    // Zero seed behaves as 16'hACE1
    start_pulse(0, 16'h0000);
    check("zero_seed_lfsr", 64'(dut_a.lfsr_q), 64'hACE1);
    model_reset(16'hACE1);
    model_run("zero_seed", 1'b0, 10);

    // Map end with MAP_LENGTH = 1000: last right clamps to 999
    start_pulse(1, 16'h1234);
    pop_expect(1, "map_rec0", {16'd0, 16'd199, 16'd60, 4'h0});
    pop_expect(1, "map_rec1", {16'd292, 16'd484, 16'd132, 4'h0});
    pop_expect(1, "map_rec2", {16'd551, 16'd707, 16'd96, 4'h0});
    pop_expect(1, "map_rec3", {16'd761, 16'd899, 16'd78, 4'h0});
    pop_expect(1, "map_rec4", {16'd946, 16'd999, 16'd149, 4'h0});
    check("map_count", 64'(count_b), 64'd5);
    rdy_b = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      if (done_b) found = 1'b1;
    end
    check("map_done_rises", 64'(found), 64'd1);
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (valid_b || !done_b) seen = 1'b1;
    end
    check("map_idle_after_done", 64'(seen), 64'd0);
    check("map_count_final", 64'(count_b), 64'd5);
    rdy_b = 1'b0;
    start_pulse(1, 16'h1234);
    check("map_restart_done_low", 64'(done_b), 64'd0);
    pop_rec(1, 1'b0, rec, ok);
    check("map_restart_left", 64'(rec[51:36]), 64'd0);

    // Reset mid-stream with a simultaneous start
    start_pulse(0, 16'h1234);
    pop_rec(0, 1'b0, rec, ok);
    pop_rec(0, 1'b0, rec, ok);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (dut_a.fifo_cnt_q >= 3) found = 1'b1;
    end
    check("mid_queued", 64'(found), 64'd1);
    check("mid_count_before", 64'(count_a), 64'd2);
    rst_n = 1'b0;
    start_a = 1'b1;
    seed_a = 16'h1234;
    @(negedge clk);
    rst_n = 1'b1;
    start_a = 1'b0;
    check("mid_valid", 64'(valid_a), 64'd0);
    check("mid_count", 64'(count_a), 64'd0);
    check("mid_state", 64'(dut_a.state_q), 64'd0);
    check("mid_lfsr", 64'(dut_a.lfsr_q), 64'hACE1);
    repeat (5) @(negedge clk);
    check("mid_start_ignored_valid", 64'(valid_a), 64'd0);
    check("mid_start_ignored_state", 64'(dut_a.state_q), 64'd0);

    // Ceiling rule and ordering over many seeds, ready held high
    ceil_bad = 0; order_bad = 0; total_recs = 0; ceil_recs = 0;
    rdy_a = 1'b1;
    for (int k = 0; k < 250; k++) begin
      s = 16'(k * 40503 + 7);
      start_pulse(0, s);
      model_reset(s);
      seq_bad = 0;
      dn = 0;
      prev_stat = 1'b0;
      prev_left = 16'd0;
      for (int c = 0; c < 300 && dn == 0; c++) begin
        @(negedge clk);
        if (done_a) begin
          dn = 1;
        end else if (valid_a) begin
          model_next(10000, exp, ended);
          if (ended || blk_a !== exp) seq_bad++;
          if (blk_a[3:1] != 3'b000 || (blk_a[0] && prev_stat)) ceil_bad++;
          if (blk_a[35:20] < blk_a[51:36]) order_bad++;
          if (total_recs > 0 && blk_a[51:36] != 16'd0 && blk_a[51:36] <= prev_left) order_bad++;
          if (blk_a[0]) ceil_recs++;
          prev_stat = blk_a[0];
          prev_left = blk_a[51:36];
          total_recs++;
        end
      end
      model_next(10000, exp, ended);
      check("sweep_done", 64'(dn), 64'd1);
      check("sweep_seq", 64'({seq_bad, 31'd0, ended}), 64'd1);
    end
    rdy_a = 1'b0;
    check("sweep_ceiling_rule", 64'(ceil_bad), 64'd0);
    check("sweep_order", 64'(order_bad), 64'd0);
    check("sweep_has_ceilings", 64'(ceil_recs > 0), 64'd1);
    check("sweep_volume", 64'(total_recs >= 9000), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
